// File: rtl/idct_transpose_buf.sv
// Ping-pong NxN transpose buffer between the row and column IDCT passes.
// Rows are written into one bank while the other bank drains column by column.
module idct_transpose_buf #(
    parameter int unsigned DW = 32,
    parameter int unsigned N  = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            row_valid,
    output logic            row_ready,
    input  logic [N*DW-1:0] row_data,
    output logic            col_valid,
    input  logic            col_ready,
    output logic [N*DW-1:0] col_data,
    output logic            busy
);

    localparam int unsigned AW = (N > 1) ? $clog2(N) : 1;
    localparam logic [AW-1:0] Last = AW'(N - 1);

    logic [DW-1:0] mem_q [2][N][N];
    logic [DW-1:0] mem_d [2][N][N];
    logic [1:0]    full_q, full_d;
    logic          wb_q, wb_d;
    logic          rb_q, rb_d;
    logic [AW-1:0] wr_row_q, wr_row_d;
    logic [AW-1:0] rd_col_q, rd_col_d;
    logic          accept;
    logic          xfer;

    always_comb begin
        row_ready = !full_q[wb_q] && !flush;
        col_valid = full_q[rb_q];
        busy      = (|full_q) || (wr_row_q != '0);
        accept    = row_valid && row_ready;
        xfer      = col_valid && col_ready && !flush;
    end

    // Column k of the output beat is row k of the read bank at the current column.
    always_comb begin
        col_data = '0;
        for (int unsigned k = 0; k < N; k++) begin
            col_data[DW*k +: DW] = mem_q[rb_q][k][rd_col_q];
        end
    end

    always_comb begin
        mem_d    = mem_q;
        full_d   = full_q;
        wb_d     = wb_q;
        rb_d     = rb_q;
        wr_row_d = wr_row_q;
        rd_col_d = rd_col_q;
        if (flush) begin
            full_d   = '0;
            wb_d     = 1'b0;
            rb_d     = 1'b0;
            wr_row_d = '0;
            rd_col_d = '0;
        end else begin
            if (accept) begin
                for (int unsigned k = 0; k < N; k++) begin
                    mem_d[wb_q][wr_row_q][k] = row_data[DW*k +: DW];
                end
                if (wr_row_q == Last) begin
                    full_d[wb_q] = 1'b1;
                    wb_d         = ~wb_q;
                    wr_row_d     = '0;
                end else begin
                    wr_row_d = wr_row_q + AW'(1);
                end
            end
            // Write sets only an empty bank and read clears only a full one, so the
            // two full_d updates can never collide on the same bit.
            if (xfer) begin
                if (rd_col_q == Last) begin
                    full_d[rb_q] = 1'b0;
                    rb_d         = ~rb_q;
                    rd_col_d     = '0;
                end else begin
                    rd_col_d = rd_col_q + AW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '{default: '0};
            full_q   <= '0;
            wb_q     <= 1'b0;
            rb_q     <= 1'b0;
            wr_row_q <= '0;
            rd_col_q <= '0;
        end else begin
            mem_q    <= mem_d;
            full_q   <= full_d;
            wb_q     <= wb_d;
            rb_q     <= rb_d;
            wr_row_q <= wr_row_d;
            rd_col_q <= rd_col_d;
        end
    end

endmodule

// File: tb/tb_idct_transpose_buf.sv
// Self-checking bench for idct_transpose_buf: block-FIFO reference model plus
// directed scenarios with hand-derived expected lane values.
module tb_idct_transpose_buf;

    localparam int DW = 32;
    localparam int N  = 8;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            flush = 1'b0;
    logic            row_valid = 1'b0;
    logic            row_ready;
    logic [N*DW-1:0] row_data = '0;
    logic            col_valid;
    logic            col_ready = 1'b0;
    logic [N*DW-1:0] col_data;
    logic            busy;

    int tests = 0;
    int fails = 0;

    idct_transpose_buf #(.DW(DW), .N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .row_valid (row_valid),
        .row_ready (row_ready),
        .row_data  (row_data),
        .col_valid (col_valid),
        .col_ready (col_ready),
        .col_data  (col_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] row_of(input logic [31:0] base, input int r);
        logic [255:0] v;
        for (int k = 0; k < N; k++) v[32*k +: 32] = base + 32'(16 * r + k);
        return v;
    endfunction

    function automatic logic [31:0] lane(input logic [255:0] v, input int k);
        return v[32*k +: 32];
    endfunction

    function automatic logic [31:0] ext(input int i);
        case (i % 3)
            0:       return 32'h8000_0000;
            1:       return 32'h7FFF_FFFF;
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

    // Reference model: a FIFO of complete blocks (capacity 2) plus one partial block.
    typedef logic [31:0] blk_t [64];
    blk_t         bq[$];
    blk_t         cur;
    int           cur_rows = 0;
    int           rcol = 0;
    bit           armed = 0;
    bit           p_acc, p_xfer, p_flush;
    logic [255:0] p_data;
    logic [255:0] m_exp;
    bit           e_ready, e_valid, e_busy;

    always @(negedge clk) begin
        if (!rst_n) begin
            bq.delete();
            cur_rows = 0;
            rcol = 0;
            armed = 0;
            chk("rst row_ready", row_ready, 1);
            chk("rst col_valid", col_valid, 0);
            chk("rst col_data", col_data, 0);
            chk("rst busy", busy, 0);
        end else begin
            e_ready = (bq.size() < 2) && !flush;
            e_valid = bq.size() > 0;
            e_busy  = (bq.size() > 0) || (cur_rows > 0);
            chk("model row_ready", row_ready, e_ready);
            chk("model col_valid", col_valid, e_valid);
            chk("model busy", busy, e_busy);
            if (e_valid) begin
                for (int k = 0; k < N; k++) m_exp[32*k +: 32] = bq[0][k*N + rcol];
                chk("model col_data", col_data, m_exp);
            end
            p_acc   = row_valid && e_ready;
            p_data  = row_data;
            p_xfer  = e_valid && col_ready && !flush;
            p_flush = flush;
            armed   = 1;
        end
    end

    always @(posedge clk) begin
        if (rst_n && armed) begin
            if (p_flush) begin
                bq.delete();
                cur_rows = 0;
                rcol = 0;
            end else begin
                if (p_xfer) begin
                    rcol++;
                    if (rcol == N) begin
                        void'(bq.pop_front());
                        rcol = 0;
                    end
                end
                if (p_acc) begin
                    for (int k = 0; k < N; k++) cur[cur_rows*N + k] = p_data[32*k +: 32];
                    cur_rows++;
                    if (cur_rows == N) begin
                        bq.push_back(cur);
                        cur_rows = 0;
                    end
                end
            end
            armed = 0;
        end
    end

    task automatic send_row(input logic [255:0] d);
        int n = 0;
        row_valid = 1'b1;
        row_data  = d;
        do begin
            @(negedge clk);
            n++;
        end while (!row_ready && n < 200);
        if (!row_ready) begin
            tests++;
            fails++;
            $display("FAIL send_row timeout: row_ready got 0 expected 1");
        end
        @(posedge clk);
        #1;
        row_valid = 1'b0;
    endtask

    task automatic send_block(input logic [31:0] base, input int nrows);
        for (int r = 0; r < nrows; r++) send_row(row_of(base, r));
    endtask

    // Expects column 0 of a block from `base` on the next falling edge, col_ready high.
    task automatic drain_check(input logic [31:0] base);
        for (int c = 0; c < N; c++) begin
            @(negedge clk);
            chk("drain col_valid", col_valid, 1);
            for (int k = 0; k < N; k++)
                chk("drain lane", lane(col_data, k), base + 32'(16 * k + c));
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        col_ready = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (col_valid && n < 100);
        chk("drain timeout col_valid", col_valid, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] v;
        #12;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single block: row r lane k = 16r+k, column c lane k = 16k+c.
        col_ready = 1'b1;
        send_block(32'h0, N);
        drain_check(32'h0);
        @(negedge clk);
        chk("single after drain col_valid", col_valid, 0);
        chk("single after drain busy", busy, 0);

        // Backpressure: two full banks, 17th row held until bank A drains.
        @(posedge clk);
        #1;
        col_ready = 1'b0;
        send_block(32'h1000, N);
        send_block(32'h2000, N);
        @(negedge clk);
        chk("bp row_ready both full", row_ready, 0);
        chk("bp busy", busy, 1);
        row_valid = 1'b1;
        row_data  = row_of(32'h3000, 0);
        repeat (3) begin
            @(negedge clk);
            chk("bp 17th row held", row_ready, 0);
        end
        @(posedge clk);
        #1;
        col_ready = 1'b1;
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            chk("bp row_ready while draining", row_ready, 0);
            chk("bp A lane0", lane(col_data, 0), 32'h1000 + 32'(i));
        end
        @(negedge clk);
        chk("bp row_ready after free", row_ready, 1);
        chk("bp B col0 lane3", lane(col_data, 3), 32'h2000 + 32'd48);
        @(posedge clk);
        #1;
        row_valid = 1'b0;
        col_ready = 1'b0;
        for (int r = 1; r < N; r++) send_row(row_of(32'h3000, r));
        wait_idle();

        // Simultaneous last-row accept and last-column transfer.
        @(posedge clk);
        #1;
        col_ready = 1'b0;
        send_block(32'h4000, N);
        send_block(32'h5000, N - 1);
        @(posedge clk);
        #1;
        col_ready = 1'b1;
        repeat (7) @(posedge clk);
        #1;
        row_valid = 1'b1;
        row_data  = row_of(32'h5000, N - 1);
        @(negedge clk);
        chk("sim row_ready", row_ready, 1);
        chk("sim A col7 lane0", lane(col_data, 0), 32'h4007);
        @(posedge clk);
        #1;
        row_valid = 1'b0;
        @(negedge clk);
        chk("sim B col_valid", col_valid, 1);
        for (int k = 0; k < N; k++)
            chk("sim B col0 lane", lane(col_data, k), 32'h5000 + 32'(16 * k));
        wait_idle();

        // Asynchronous reset mid-drain.
        @(posedge clk);
        #1;
        col_ready = 1'b0;
        send_block(32'h6000, N);
        @(posedge clk);
        #1;
        col_ready = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async rst row_ready", row_ready, 1);
        chk("async rst col_valid", col_valid, 0);
        chk("async rst col_data", col_data, 0);
        chk("async rst busy", busy, 0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        col_ready = 1'b1;
        @(posedge clk);
        #1;

        // Extreme values: row r lane k = ext(r+2k), so column c lane k = ext(k+2c).
        for (int r = 0; r < N; r++) begin
            for (int k = 0; k < N; k++) v[32*k +: 32] = ext(r + 2 * k);
            send_row(v);
        end
        for (int c = 0; c < N; c++) begin
            @(negedge clk);
            chk("ext col_valid", col_valid, 1);
            for (int k = 0; k < N; k++) chk("ext lane", lane(col_data, k), ext(k + 2 * c));
        end

        // Flush after three rows, with a row offered in the same cycle.
        @(posedge clk);
        #1;
        send_block(32'h7000, 3);
        row_valid = 1'b1;
        row_data  = row_of(32'h7000, 3);
        flush     = 1'b1;
        @(negedge clk);
        chk("flush row_ready", row_ready, 0);
        @(posedge clk);
        #1;
        flush     = 1'b0;
        row_valid = 1'b0;
        @(negedge clk);
        chk("flush busy", busy, 0);
        chk("flush col_valid", col_valid, 0);
        @(posedge clk);
        #1;
        send_block(32'h8000, N);
        drain_check(32'h8000);
        @(negedge clk);
        chk("final idle busy", busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
